// File: rtl/peripheral_rxfifo_if.sv
// rtl/peripheral_rxfifo_if.sv - J1 I/O bus and UART receive strobe bundle for the RX FIFO peripheral
interface peripheral_rxfifo_if #(
  parameter int DW = 8
);
  logic [15:0]   d_in;
  logic          cs;
  logic [3:0]    addr;
  logic          rd;
  logic          wr;
  logic [15:0]   d_out;
  logic [DW-1:0] rx_data;
  logic          rx_avail;

  modport master (
    output d_in, cs, addr, rd, wr, rx_data, rx_avail,
    input  d_out
  );

  modport slave (
    input  d_in, cs, addr, rd, wr, rx_data, rx_avail,
    output d_out
  );
endinterface

// File: rtl/peripheral_rxfifo.sv
// rtl/peripheral_rxfifo.sv - UART receive FIFO on the J1 I/O bus with fill/overflow/underflow status
// Optional CR/LF line counter and line-ready interrupt enabled by RXFIFO_LINECNT_EN.
module peripheral_rxfifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DW         = 8
) (
  input  logic                clk,
  input  logic                rst,
  peripheral_rxfifo_if.slave  bus,
  output logic                irq,
  output logic                full
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DW-1:0]         mem_q [DEPTH];
  logic [DW-1:0]         mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  rd_q, rd_d;
  logic [4:0]            lines_q, lines_d;

  logic          empty, rd_sel, pop_req, pop_ok, push_ok;
  logic          ctrl_wr, flush, clr_flags;
  logic [DW-1:0] head;
  logic          unused_d_in;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_CNT);
  assign head      = mem_q[rd_ptr_q];
  assign rd_sel    = bus.cs & bus.rd & (bus.addr == 4'h0);
  // Edge-detect the read strobe so a held rd pops exactly once.
  assign pop_req   = rd_sel & ~rd_q;
  assign pop_ok    = pop_req & ~empty;
  assign push_ok   = bus.rx_avail & (~full | pop_ok);
  assign ctrl_wr   = bus.cs & bus.wr & (bus.addr == 4'h8);
  assign flush     = ctrl_wr & bus.d_in[0];
  assign clr_flags = ctrl_wr & bus.d_in[1];
  assign unused_d_in = ^bus.d_in[15:2];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    lines_d  = lines_q;
    rd_d     = rd_sel;

    if (clr_flags) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (bus.rx_avail & full & ~pop_ok & ~flush) ovf_d = 1'b1;
    if (pop_req & empty) udf_d = 1'b1;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      lines_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = bus.rx_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
`ifdef RXFIFO_LINECNT_EN
      case ({push_ok & (bus.rx_data == DW'('h0A)), pop_ok & (head == DW'('h0A))})
        2'b10:   if (lines_q != 5'd31) lines_d = lines_q + 5'd1;
        2'b01:   if (lines_q != 5'd0)  lines_d = lines_q - 5'd1;
        default: lines_d = lines_q;
      endcase
`else
      lines_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      rd_q     <= 1'b0;
      lines_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      rd_q     <= rd_d;
      lines_q  <= lines_d;
    end
  end

  // DATA shows the head whenever non-empty; a push into an empty FIFO is not bypassed.
  always_comb begin
    bus.d_out = 16'h0000;
    if (bus.cs) begin
      case (bus.addr)
        4'h0:    if (!empty) bus.d_out = 16'(head);
        4'h2:    bus.d_out = {11'b0, udf_q, ovf_q, lines_q != 5'd0, full, empty};
        4'h4:    bus.d_out = 16'(count_q);
        4'h6:    bus.d_out = {11'b0, lines_q};
        default: bus.d_out = 16'h0000;
      endcase
    end
  end

`ifdef RXFIFO_LINECNT_EN
  assign irq = (lines_q != 5'd0);
`else
  assign irq = ~empty;
`endif
endmodule

// File: tb/tb_peripheral_rxfifo.sv
// tb/tb_peripheral_rxfifo.sv - directed and randomized bench for peripheral_rxfifo against a queue model
module tb_peripheral_rxfifo;
  logic clk;
  logic rst;
  logic irq;
  logic full;
  peripheral_rxfifo_if #(.DW(8)) bus ();

  peripheral_rxfifo #(.DEPTH_LOG2(4), .DW(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .irq  (irq),
    .full (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0]  q[$];
  bit          m_ovf, m_udf, m_rdprev;
  logic [15:0] last_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int m_lines();
    int n = 0;
`ifdef RXFIFO_LINECNT_EN
    foreach (q[i]) if (q[i] == 8'h0A) n++;
`endif
    return n;
  endfunction

  function automatic logic [15:0] m_dout(input logic cs, input logic [3:0] addr);
    if (!cs) return 16'h0;
    case (addr)
      4'h0:    return (q.size() == 0) ? 16'h0 : {8'h00, q[0]};
      4'h2:    return {11'b0, m_udf, m_ovf, m_lines() != 0, q.size() == 16, q.size() == 0};
      4'h4:    return 16'(q.size());
      4'h6:    return 16'(m_lines());
      default: return 16'h0;
    endcase
  endfunction

  task automatic m_reset();
    q.delete();
    m_ovf = 0;
    m_udf = 0;
    m_rdprev = 0;
  endtask

  task automatic do_cycle(input logic cs, input logic rd, input logic wr, input logic [3:0] addr,
                          input logic [15:0] din, input logic av, input logic [7:0] data,
                          input string tag);
    bit rdsel, pop, popped, pushok, ctrl, flush, clr, was_full, was_empty;
    bus.cs = cs; bus.rd = rd; bus.wr = wr; bus.addr = addr;
    bus.d_in = din; bus.rx_avail = av; bus.rx_data = data;
    @(negedge clk);
    last_dout = bus.d_out;
    check({tag, "_dout"}, bus.d_out, m_dout(cs, addr));
`ifdef RXFIFO_LINECNT_EN
    check({tag, "_irq"}, irq, m_lines() != 0);
`else
    check({tag, "_irq"}, irq, q.size() != 0);
`endif
    check({tag, "_full"}, full, q.size() == 16);

    rdsel     = cs && rd && addr == 4'h0;
    pop       = rdsel && !m_rdprev;
    m_rdprev  = rdsel;
    ctrl      = cs && wr && addr == 4'h8;
    flush     = ctrl && din[0];
    clr       = ctrl && din[1];
    was_full  = q.size() == 16;
    was_empty = q.size() == 0;
    popped    = pop && !was_empty;
    pushok    = av && (!was_full || popped);
    if (clr) begin m_ovf = 0; m_udf = 0; end
    if (av && was_full && !popped && !flush) m_ovf = 1;
    if (pop && was_empty) m_udf = 1;
    if (flush) q.delete();
    else begin
      if (popped) void'(q.pop_front());
      if (pushok) q.push_back(data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    do_cycle(0, 0, 0, 4'h0, 16'h0, 0, 8'h00, "idle");
  endtask

  task automatic push(input logic [7:0] b);
    do_cycle(0, 0, 0, 4'h0, 16'h0, 1, b, "push");
  endtask

  task automatic rdreg(input logic [3:0] a, input string tag, output logic [15:0] v);
    do_cycle(1, 1, 0, a, 16'h0, 0, 8'h00, tag);
    v = last_dout;
    idle();
  endtask

  task automatic wrctrl(input logic [15:0] v);
    do_cycle(1, 0, 1, 4'h8, v, 0, 8'h00, "ctrl");
  endtask

  logic [15:0] v;
  logic [7:0]  t2_bytes [4];

  initial begin
    t2_bytes = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
    rst = 1'b1;
    bus.cs = 0; bus.rd = 0; bus.wr = 0; bus.addr = 0;
    bus.d_in = 0; bus.rx_avail = 0; bus.rx_data = 0;
    m_reset();
    @(posedge clk);
    #1;
    check("rst_dout", bus.d_out, 16'h0);
    check("rst_irq", irq, 1'b0);
    check("rst_full", full, 1'b0);
    rst = 1'b0;

    rdreg(4'h2, "t1_status", v);
    check("t1_status_val", v, 16'h0001);

    foreach (t2_bytes[i]) push(t2_bytes[i]);
    rdreg(4'h4, "t2_count", v);
    check("t2_count_val", v, 16'd4);
`ifdef RXFIFO_LINECNT_EN
    rdreg(4'h6, "t2_lines", v);
    check("t2_lines_val", v, 16'd1);
`endif
    foreach (t2_bytes[i]) begin
      rdreg(4'h0, "t2_data", v);
      check("t2_data_val", v, {8'h00, t2_bytes[i]});
    end
    rdreg(4'h2, "t2_status", v);
    check("t2_status_val", v, 16'h0001);
`ifdef RXFIFO_LINECNT_EN
    rdreg(4'h6, "t2_lines0", v);
    check("t2_lines0_val", v, 16'd0);
`endif

    for (int i = 0; i < 17; i++) push(8'(i));
    check("t3_full", full, 1'b1);
    rdreg(4'h2, "t3_status", v);
`ifdef RXFIFO_LINECNT_EN
    check("t3_status_val", v, 16'h000E);
`else
    check("t3_status_val", v, 16'h000A);
`endif
    for (int i = 0; i < 16; i++) begin
      rdreg(4'h0, "t3_data", v);
      check("t3_data_val", v, 16'(i));
    end
    wrctrl(16'h0002);
    rdreg(4'h2, "t3_clr", v);
    check("t3_clr_val", v, 16'h0001);

    push(8'h11);
    push(8'h22);
    for (int i = 0; i < 5; i++) do_cycle(1, 1, 0, 4'h0, 16'h0, 0, 8'h00, "t4_hold");
    idle();
    rdreg(4'h4, "t4_count", v);
    check("t4_count_val", v, 16'd1);
    rdreg(4'h0, "t4_data", v);
    check("t4_data_val", v, 16'h0022);

    for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
    do_cycle(1, 1, 0, 4'h0, 16'h0, 1, 8'hAA, "t5_pushpop");
    idle();
    rdreg(4'h4, "t5_count", v);
    check("t5_count_val", v, 16'd16);
    rdreg(4'h2, "t5_status", v);
    check("t5_status_val", v, 16'h0002);
    for (int i = 0; i < 15; i++) rdreg(4'h0, "t5_drain", v);
    rdreg(4'h0, "t5_aa", v);
    check("t5_aa_val", v, 16'h00AA);

    rdreg(4'h0, "t6_empty_rd", v);
    check("t6_empty_rd_val", v, 16'h0000);
    rdreg(4'h2, "t6_udf", v);
    check("t6_udf_val", v, 16'h0011);
    wrctrl(16'h0002);
    push(8'h01); push(8'h02); push(8'h03);
    wrctrl(16'h0001);
    rdreg(4'h4, "t6_flush", v);
    check("t6_flush_val", v, 16'd0);
    push(8'h07);
    do_cycle(1, 0, 1, 4'h8, 16'h0001, 1, 8'h55, "t6_flushpush");
    rdreg(4'h4, "t6_fp_count", v);
    check("t6_fp_count_val", v, 16'd0);
    push(8'h41);
    rdreg(4'h0, "t6_after_flush", v);
    check("t6_after_flush_val", v, 16'h0041);

    push(8'h0A); push(8'h62); push(8'h63);
    bus.cs = 1; bus.rd = 0; bus.wr = 0; bus.addr = 4'h4; bus.rx_avail = 0;
    #1;
    check("t6_pre_rst", bus.d_out, 16'd3);
    rst = 1'b1;
    #1;
    check("t6_async_rst", bus.d_out, 16'd0);
    check("t6_async_rst_irq", irq, 1'b0);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdreg(4'h2, "t6_post_rst", v);
    check("t6_post_rst_val", v, 16'h0001);

    for (int n = 0; n < 1500; n++) begin
      logic        cs, rd, wr, av;
      logic [3:0]  addr;
      logic [15:0] din;
      logic [7:0]  data;
      int          sel;
      cs  = ($urandom_range(0, 9) != 0);
      rd  = ($urandom_range(0, 1) == 1);
      av  = ((n / 150) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 5);
      case (sel)
        0: addr = 4'h0;
        1: addr = 4'h2;
        2: addr = 4'h4;
        3: addr = 4'h6;
        4: addr = 4'h8;
        default: addr = 4'($urandom);
      endcase
      wr   = !rd && !av && ($urandom_range(0, 7) == 0);
      din  = 16'($urandom);
      din[0] = ($urandom_range(0, 3) == 0);
      data = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
      do_cycle(cs, rd, wr, addr, din, av, data, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
